// File: rtl/fpnew_pkg.sv
// Shared FP format descriptors, classifier info struct and the FCLASS class mask encoding.
package fpnew_pkg;

  typedef enum logic [2:0] {
    FP32    = 3'd0,
    FP64    = 3'd1,
    FP16    = 3'd2,
    FP8     = 3'd3,
    FP16ALT = 3'd4
  } fp_format_e;

  localparam int unsigned NUM_FP_FORMATS = 5;

  typedef struct packed {
    int unsigned exp_bits;
    int unsigned man_bits;
  } fp_encoding_t;

  localparam fp_encoding_t [0:NUM_FP_FORMATS-1] FP_ENCODINGS = '{
    '{8, 23}, '{11, 52}, '{5, 10}, '{5, 2}, '{8, 7}
  };

  typedef struct packed {
    logic is_normal;
    logic is_subnormal;
    logic is_zero;
    logic is_inf;
    logic is_nan;
    logic is_signalling;
    logic is_quiet;
    logic is_boxed;
  } fp_info_t;

  localparam int unsigned CLASS_MASK_BITS = 10;

  typedef enum logic [CLASS_MASK_BITS-1:0] {
    NEGINF     = 10'h001,
    NEGNORM    = 10'h002,
    NEGSUBNORM = 10'h004,
    NEGZERO    = 10'h008,
    POSZERO    = 10'h010,
    POSSUBNORM = 10'h020,
    POSNORM    = 10'h040,
    POSINF     = 10'h080,
    SNAN       = 10'h100,
    QNAN       = 10'h200
  } classmask_e;

  function automatic int unsigned exp_bits(fp_format_e fmt);
    return FP_ENCODINGS[fmt].exp_bits;
  endfunction

  function automatic int unsigned man_bits(fp_format_e fmt);
    return FP_ENCODINGS[fmt].man_bits;
  endfunction

  function automatic int unsigned fp_width(fp_format_e fmt);
    return FP_ENCODINGS[fmt].exp_bits + FP_ENCODINGS[fmt].man_bits + 1;
  endfunction

endpackage

// File: rtl/fpnew_classifier.sv
// Combinational IEEE-754 classifier; an operand that is not NaN-boxed reports as a quiet NaN.
module fpnew_classifier
  import fpnew_pkg::*;
#(
  parameter fp_format_e  FpFormat    = FP32,
  parameter int unsigned NumOperands = 1,
  localparam int unsigned WIDTH      = fp_width(FpFormat)
) (
  input  logic     [NumOperands-1:0][WIDTH-1:0] operands_i,
  input  logic     [NumOperands-1:0]            is_boxed_i,
  output fp_info_t [NumOperands-1:0]            info_o
);

  localparam int unsigned EXP_BITS = exp_bits(FpFormat);
  localparam int unsigned MAN_BITS = man_bits(FpFormat);

  for (genvar op = 0; op < int'(NumOperands); op++) begin : gen_op
    logic [EXP_BITS-1:0] exp_v;
    logic [MAN_BITS-1:0] man_v;
    logic                exp_zero, exp_ones, man_zero, boxed;
    logic                unused_sign;

    assign unused_sign = operands_i[op][WIDTH-1];
    assign exp_v       = operands_i[op][WIDTH-2 -: EXP_BITS];
    assign man_v       = operands_i[op][MAN_BITS-1:0];
    assign boxed       = is_boxed_i[op];
    assign exp_zero    = ~|exp_v;
    assign exp_ones    = &exp_v;
    assign man_zero    = ~|man_v;

    // Signalling NaNs have a clear quiet bit (mantissa MSB).
    assign info_o[op].is_normal     = boxed & ~exp_zero & ~exp_ones;
    assign info_o[op].is_zero       = boxed & exp_zero & man_zero;
    assign info_o[op].is_subnormal  = boxed & exp_zero & ~man_zero;
    assign info_o[op].is_inf        = boxed & exp_ones & man_zero;
    assign info_o[op].is_nan        = ~boxed | (exp_ones & ~man_zero);
    assign info_o[op].is_signalling = boxed & exp_ones & ~man_zero & ~man_v[MAN_BITS-1];
    assign info_o[op].is_quiet      = ~boxed | (exp_ones & man_v[MAN_BITS-1]);
    assign info_o[op].is_boxed      = boxed;
  end

endmodule

// File: rtl/fpnew_fclass_unit.sv
// FCLASS unit: NaN-box check, classify, encode the 10-bit class mask and carry it with a tag
// through a valid/ready register chain of NumPipeRegs stages.
module fpnew_fclass_unit
  import fpnew_pkg::*;
#(
  parameter fp_format_e  FpFormat    = FP32,
  parameter int unsigned Width       = 64,
  parameter int unsigned NumPipeRegs = 1,
  parameter int unsigned TagWidth    = 4
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic [Width-1:0]    operand_i,
  input  logic [TagWidth-1:0] tag_i,
  input  logic                in_valid_i,
  output logic                in_ready_o,
  input  logic                flush_i,
  output logic [Width-1:0]    result_o,
  output logic [TagWidth-1:0] tag_o,
  output logic                out_valid_o,
  input  logic                out_ready_i,
  output logic                busy_o
);

  localparam int unsigned WIDTH = fp_width(FpFormat);

  logic                       is_boxed;
  logic                       sign;
  fp_info_t [0:0]             info;
  logic [CLASS_MASK_BITS-1:0] mask_c;
  logic                       unused_nan;

  if (Width > WIDTH) begin : gen_box
    assign is_boxed = &operand_i[Width-1:WIDTH];
  end else begin : gen_nobox
    assign is_boxed = 1'b1;
  end

  assign sign = operand_i[WIDTH-1];

  fpnew_classifier #(
    .FpFormat    (FpFormat),
    .NumOperands (1)
  ) i_classifier (
    .operands_i (operand_i[WIDTH-1:0]),
    .is_boxed_i (is_boxed),
    .info_o     (info)
  );

  assign unused_nan = info[0].is_nan;

  // One-hot class mask; unboxed operands land on qNaN via is_quiet.
  always_comb begin
    mask_c = '0;
    if (info[0].is_signalling)     mask_c = SNAN;
    else if (info[0].is_quiet)     mask_c = QNAN;
    else if (info[0].is_inf)       mask_c = sign ? NEGINF     : POSINF;
    else if (info[0].is_normal)    mask_c = sign ? NEGNORM    : POSNORM;
    else if (info[0].is_subnormal) mask_c = sign ? NEGSUBNORM : POSSUBNORM;
    else if (info[0].is_zero)      mask_c = sign ? NEGZERO    : POSZERO;
  end

  if (NumPipeRegs == 0) begin : gen_comb
    logic unused_pipe;
    assign unused_pipe = clk_i ^ rst_ni ^ flush_i;
    assign out_valid_o = in_valid_i;
    assign in_ready_o  = out_ready_i;
    assign result_o    = Width'(mask_c);
    assign tag_o       = tag_i;
    assign busy_o      = 1'b0;
  end else begin : gen_pipe
    localparam int unsigned N = NumPipeRegs;

    logic [N:0]                            ready;
    logic [N-1:0]                          valid_q, valid_d;
    logic [N-1:0][CLASS_MASK_BITS-1:0]     mask_q, mask_d;
    logic [N-1:0][TagWidth-1:0]            tag_q, tag_d;

    // Stage k is offered what stage k-1 holds; stage 0 is offered the input.
    always_comb begin
      valid_d    = '0;
      mask_d     = '0;
      tag_d      = '0;
      valid_d[0] = in_valid_i;
      mask_d[0]  = mask_c;
      tag_d[0]   = tag_i;
      for (int unsigned k = 1; k < N; k++) begin
        valid_d[k] = valid_q[k-1];
        mask_d[k]  = mask_q[k-1];
        tag_d[k]   = tag_q[k-1];
      end
    end

    // Ready ripples back from the output: a stage accepts if empty or draining.
    always_comb begin
      logic acc;
      ready    = '0;
      acc      = out_ready_i;
      ready[N] = acc;
      for (int k = int'(N) - 1; k >= 0; k--) begin
        acc      = acc | ~valid_q[k];
        ready[k] = acc;
      end
    end

    always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
        valid_q <= '0;
        mask_q  <= '0;
        tag_q   <= '0;
      end else begin
        for (int unsigned k = 0; k < N; k++) begin
          if (flush_i)       valid_q[k] <= 1'b0;
          else if (ready[k]) valid_q[k] <= valid_d[k];
          if (valid_d[k] && ready[k]) begin
            mask_q[k] <= mask_d[k];
            tag_q[k]  <= tag_d[k];
          end
        end
      end
    end

    assign in_ready_o  = ready[0] & ~flush_i;
    assign out_valid_o = valid_q[N-1];
    assign result_o    = Width'(mask_q[N-1]);
    assign tag_o       = tag_q[N-1];
    assign busy_o      = |valid_q;
  end

endmodule

// File: tb/tb_fpnew_fclass_unit.sv
// Scoreboard bench for fpnew_fclass_unit (FP32, 64-bit operands, two pipeline stages).
module tb_fpnew_fclass_unit;

  localparam int unsigned NPIPE = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [63:0] operand;
  logic [3:0]  tag_in;
  logic        in_valid;
  logic        in_ready;
  logic        flush;
  logic [63:0] result;
  logic [3:0]  tag_out;
  logic        out_valid;
  logic        out_ready;
  logic        busy;
  logic [9:0]  exp_in;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          cyc      = 0;
  logic [13:0] sb_q[$];
  logic        stalled_prev = 1'b0;
  logic [63:0] prev_res;
  logic [3:0]  prev_tag;

  fpnew_fclass_unit #(
    .FpFormat    (fpnew_pkg::FP32),
    .Width       (64),
    .NumPipeRegs (NPIPE),
    .TagWidth    (4)
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .operand_i   (operand),
    .tag_i       (tag_in),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .flush_i     (flush),
    .result_o    (result),
    .tag_o       (tag_out),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .busy_o      (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  function automatic logic [9:0] ref_class(input logic [63:0] op);
    logic        s;
    logic [7:0]  e;
    logic [22:0] m;
    s = op[31];
    e = op[30:23];
    m = op[22:0];
    if (op[63:32] != 32'hFFFF_FFFF) return 10'h200;
    if (e == 8'hFF) begin
      if (m == 23'd0) return s ? 10'h001 : 10'h080;
      return m[22] ? 10'h200 : 10'h100;
    end
    if (e == 8'h00) begin
      if (m == 23'd0) return s ? 10'h008 : 10'h010;
      return s ? 10'h004 : 10'h020;
    end
    return s ? 10'h002 : 10'h040;
  endfunction

  // Scoreboard: push on input handshake, pop and compare on output handshake.
  always @(negedge clk) begin
    logic [13:0] e;
    if (!rst_n) begin
      sb_q.delete();
      stalled_prev = 1'b0;
    end else begin
      if (out_valid && out_ready) begin
        if (sb_q.size() == 0) check("unexp_out", 64'd1, 64'd0);
        else begin
          e = sb_q.pop_front();
          check("result", result, {54'd0, e[9:0]});
          check("tag", {60'd0, tag_out}, {60'd0, e[13:10]});
        end
      end
      if (stalled_prev && out_valid) begin
        check("stable_res", result, prev_res);
        check("stable_tag", {60'd0, tag_out}, {60'd0, prev_tag});
      end
      stalled_prev = out_valid && !out_ready;
      prev_res     = result;
      prev_tag     = tag_out;
      if (flush) sb_q.delete();
      else if (in_valid && in_ready) sb_q.push_back({tag_in, exp_in});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [63:0] op, input logic [3:0] t, input logic [9:0] e);
    operand  = op;
    tag_in   = t;
    exp_in   = e;
    in_valid = 1'b1;
  endtask

  task automatic send(input logic [63:0] op, input logic [3:0] t, input logic [9:0] e);
    int   n;
    logic hs;
    drive(op, t, e);
    n  = 0;
    hs = 1'b0;
    while (!hs && n <= 200) begin
      @(negedge clk);
      hs = in_ready;
      tick();
      n++;
    end
    if (!hs) check("send_timeout", 64'd0, 64'd1);
    in_valid = 1'b0;
  endtask

  task automatic lat_test(input logic [63:0] op, input logic [3:0] t, input logic [9:0] e);
    int n;
    drive(op, t, e);
    n = 0;
    do begin
      tick();
      n++;
      in_valid = 1'b0;
    end while (!out_valid && n < 20);
    check("latency", 64'(n), 64'(NPIPE));
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((sb_q.size() != 0 || out_valid) && n < 200) begin
      tick();
      n++;
    end
    check("drain", 64'(sb_q.size()), 64'd0);
  endtask

  logic [63:0] dir_op [8] = '{
    64'hFFFFFFFF_3F800000, 64'hFFFFFFFF_FF800000, 64'hFFFFFFFF_80000000, 64'hFFFFFFFF_00000001,
    64'hFFFFFFFF_7F800001, 64'hFFFFFFFF_7FC00000, 64'h00000000_3F800000, 64'h7FFFFFFF_BF800000
  };
  logic [9:0] dir_exp [8] = '{
    10'h040, 10'h001, 10'h008, 10'h020, 10'h100, 10'h200, 10'h200, 10'h200
  };

  initial begin
    int c0;
    rst_n = 1'b0; operand = '0; tag_in = '0; in_valid = 1'b0;
    flush = 1'b0; out_ready = 1'b1; exp_in = '0;
    repeat (3) tick();
    check("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_result", result, 64'd0);
    check("rst_tag", {60'd0, tag_out}, 64'd0);
    check("rst_in_ready", {63'd0, in_ready}, 64'd1);
    rst_n = 1'b1;
    tick();

    lat_test(64'hFFFFFFFF_3F800000, 4'hA, 10'h040);
    drain();

    // Directed classes back-to-back; input side must sustain one op per cycle.
    c0 = cyc;
    for (int i = 0; i < 8; i++) send(dir_op[i], 4'(i), dir_exp[i]);
    check("throughput", 64'(cyc - c0), 64'd8);
    drain();

    // Backpressure: two accepted, third stalls until the output drains.
    out_ready = 1'b0;
    drive(64'hFFFFFFFF_3F800000, 4'd1, 10'h040);
    @(negedge clk); check("bp_rdy1", {63'd0, in_ready}, 64'd1);
    tick();
    drive(64'hFFFFFFFF_BF800000, 4'd2, 10'h002);
    @(negedge clk); check("bp_rdy2", {63'd0, in_ready}, 64'd1);
    tick();
    drive(64'hFFFFFFFF_00000000, 4'd3, 10'h010);
    @(negedge clk); check("bp_rdy3", {63'd0, in_ready}, 64'd0);
    repeat (3) tick();
    check("bp_full_rdy", {63'd0, in_ready}, 64'd0);
    out_ready = 1'b1;
    send(64'hFFFFFFFF_00000000, 4'd3, 10'h010);
    drain();

    // Flush with two in flight; the same-cycle input must be refused.
    out_ready = 1'b0;
    send(64'hFFFFFFFF_3F800000, 4'd4, 10'h040);
    send(64'hFFFFFFFF_7F800000, 4'd5, 10'h080);
    drive(64'hFFFFFFFF_80000001, 4'd9, 10'h004);
    flush = 1'b1;
    @(negedge clk); check("flush_rdy", {63'd0, in_ready}, 64'd0);
    tick();
    flush = 1'b0; in_valid = 1'b0;
    check("flush_busy", {63'd0, busy}, 64'd0);
    check("flush_valid", {63'd0, out_valid}, 64'd0);
    out_ready = 1'b1;
    repeat (4) tick();
    check("flush_noacc", {63'd0, out_valid}, 64'd0);

    // Synchronous reset mid-operation.
    out_ready = 1'b0;
    send(64'hFFFFFFFF_3F800000, 4'd6, 10'h040);
    send(64'hFFFFFFFF_FF800000, 4'd7, 10'h001);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rst_not_before", {63'd0, out_valid}, 64'd1);
    tick();
    check("mrst_valid", {63'd0, out_valid}, 64'd0);
    check("mrst_result", result, 64'd0);
    check("mrst_tag", {60'd0, tag_out}, 64'd0);
    check("mrst_busy", {63'd0, busy}, 64'd0);
    rst_n = 1'b1; out_ready = 1'b1;
    tick();
    lat_test(64'hFFFFFFFF_FF800000, 4'hB, 10'h001);
    drain();

    // Random stream with random output backpressure.
    fork
      begin
        for (int i = 0; i < 100; i++) begin
          logic [63:0] op;
          logic [7:0]  e;
          logic [22:0] m;
          m = 23'($urandom);
          case ($urandom_range(0, 5))
            0: e = 8'hFF;
            1: e = 8'h00;
            2: begin e = 8'h00; m = '0; end
            3: begin e = 8'hFF; m = '0; end
            default: e = 8'($urandom);
          endcase
          op[31]    = 1'($urandom);
          op[30:23] = e;
          op[22:0]  = m;
          op[63:32] = ($urandom_range(0, 3) == 0) ? 32'($urandom) : 32'hFFFF_FFFF;
          send(op, 4'(i), ref_class(op));
        end
      end
      begin
        forever begin
          @(posedge clk);
          #2;
          out_ready = 1'($urandom);
        end
      end
    join_any
    disable fork;
    out_ready = 1'b1;
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
